// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD pixel path: pixel-mode codes, unpacker
// states and per-mode geometry helpers used by the unpacker and encoder.
package lcd_pkg;

  localparam int FIFO_W = 32;
  localparam int PIX_W  = 24;

  // Pixel-mode codes exactly as they appear on lcdbpp.
  typedef enum logic [2:0] {
    BPP1       = 3'b000,
    BPP2       = 3'b001,
    BPP4       = 3'b010,
    BPP8       = 3'b011,
    BPP16_1555 = 3'b100,
    BPP24      = 3'b101,
    BPP16_565  = 3'b110,
    BPP12      = 3'b111
  } bpp_e;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT
  } unpack_state_e;

  // Pixels per 32-bit frame-buffer word.
  function automatic logic [5:0] ppw_of(bpp_e bpp);
    case (bpp)
      BPP1:    return 6'd32;
      BPP2:    return 6'd16;
      BPP4:    return 6'd8;
      BPP8:    return 6'd4;
      BPP24:   return 6'd1;
      default: return 6'd2;   // both 16bpp formats and 12bpp
    endcase
  endfunction

  // Container width of one pixel inside the word.
  function automatic logic [5:0] cw_of(bpp_e bpp);
    case (bpp)
      BPP1:    return 6'd1;
      BPP2:    return 6'd2;
      BPP4:    return 6'd4;
      BPP8:    return 6'd8;
      BPP24:   return 6'd32;
      default: return 6'd16;
    endcase
  endfunction

  // Number of meaningful bits inside a container.
  function automatic logic [4:0] aw_of(bpp_e bpp);
    case (bpp)
      BPP1:    return 5'd1;
      BPP2:    return 5'd2;
      BPP4:    return 5'd4;
      BPP8:    return 5'd8;
      BPP24:   return 5'd24;
      BPP12:   return 5'd12;
      default: return 5'd16;  // 1:5:5:5 and 5:6:5
    endcase
  endfunction

endpackage

// File: rtl/lcd_pixel_extract.sv
// Combinational pixel selector: picks pixel idx out of a frame-buffer word
// for the given mode and pixel order, masks it to its active bits and
// zero-extends it to the encoder width.
//   word  : 32-bit frame-buffer word
//   idx   : pixel index within the word (0 = first pixel sent)
//   bpp   : pixel mode
//   bepp  : 0 = pixel0 at LSBs, 1 = pixel0 at MSBs
//   pixel : zero-extended pixel
module lcd_pixel_extract
  import lcd_pkg::*;
#(
  parameter int FIFO_W = lcd_pkg::FIFO_W,
  parameter int PIX_W  = lcd_pkg::PIX_W
) (
  input  logic [FIFO_W-1:0] word,
  input  logic [4:0]        idx,
  input  bpp_e              bpp,
  input  logic              bepp,
  output logic [PIX_W-1:0]  pixel
);

  logic [5:0]        ppw;
  logic [5:0]        cw;
  logic [4:0]        aw;
  logic [4:0]        pos;
  logic [4:0]        shamt;
  logic [FIFO_W-1:0] shifted;
  logic [FIFO_W-1:0] mask;

  always_comb begin
    ppw   = ppw_of(bpp);
    cw    = cw_of(bpp);
    aw    = aw_of(bpp);
    // Big-endian order counts containers from the top; at 24bpp ppw=1 so
    // both orders resolve to container 0.
    pos   = bepp ? 5'(ppw - 6'd1 - {1'b0, idx}) : idx;
    // pos*cw never exceeds 31 for any legal idx, so 5 bits hold the offset.
    shamt = 5'({1'b0, pos} * cw);
    shifted = word >> shamt;
    mask    = (FIFO_W'(1) << aw) - FIFO_W'(1);
    pixel   = PIX_W'(shifted & mask);
  end

endmodule

// File: rtl/lcd_pixel_unpacker.sv
// Frame-buffer word unpacker between the DMA FIFO and the TFT/STN encoder.
// Pops 32-bit words, splits them into pixels by lcdbpp/lcdbepp and presents
// one pixel per handshake.
//   clk, rst            : clock, asynchronous active-high reset
//   lcden, frame_clr    : enable (low flushes) and start-of-frame flush
//   lcdbpp, lcdbepp     : pixel mode and pixel order (latched per word)
//   fifo_empty, fifo_rd : FIFO status and pop strobe (data next cycle)
//   fifo_rdata          : FIFO read data
//   ps_data, ps_valid   : pixel to the encoder and its valid
//   ps_ready            : encoder accepts the pixel
//   underrun            : one-cycle pulse per starved cycle
module lcd_pixel_unpacker
  import lcd_pkg::*;
#(
  parameter int FIFO_W = lcd_pkg::FIFO_W,
  parameter int PIX_W  = lcd_pkg::PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lcden,
  input  logic              frame_clr,
  input  logic [2:0]        lcdbpp,
  input  logic              lcdbepp,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [FIFO_W-1:0] fifo_rdata,
  output logic [PIX_W-1:0]  ps_data,
  output logic              ps_valid,
  input  logic              ps_ready,
  output logic              underrun
);

  unpack_state_e     state;
  logic [4:0]        idx;
  logic [FIFO_W-1:0] word_q;
  bpp_e              bpp_q;
  logic              bepp_q;

  logic              flush;
  logic              hs;
  logic              at_last;
  logic [FIFO_W-1:0] ex_word;
  logic [4:0]        ex_idx;
  bpp_e              ex_bpp;
  logic              ex_bepp;
  logic [PIX_W-1:0]  ex_pixel;

  assign flush   = frame_clr || !lcden;
  assign hs      = ps_valid && ps_ready;
  assign at_last = (idx == 5'(ppw_of(bpp_q) - 6'd1));

  // The pop must go out in the decision cycle so the word is on fifo_rdata
  // during FETCH; a registered strobe would cost an extra bubble per word.
  assign fifo_rd = !rst && !flush && !fifo_empty &&
                   ((state == IDLE) || (state == SHIFT && hs && at_last));

  // The extractor looks one step ahead so ps_data can be registered: in
  // FETCH it sees the incoming word and mode, in SHIFT the next index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    ex_word = word_q;
    ex_idx  = idx + 5'd1;
    ex_bpp  = bpp_q;
    ex_bepp = bepp_q;
    if (state == FETCH) begin
      ex_word = fifo_rdata;
      ex_idx  = 5'd0;
      ex_bpp  = bpp_e'(lcdbpp);
      ex_bepp = lcdbepp;
    end
  end

  lcd_pixel_extract #(
    .FIFO_W (FIFO_W),
    .PIX_W  (PIX_W)
  ) u_extract (
    .word  (ex_word),
    .idx   (ex_idx),
    .bpp   (ex_bpp),
    .bepp  (ex_bepp),
    .pixel (ex_pixel)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= 5'd0;
      word_q   <= '0;
      bpp_q    <= BPP1;
      bepp_q   <= 1'b0;
      ps_data  <= '0;
      ps_valid <= 1'b0;
      underrun <= 1'b0;
    end else begin
      // Starvation is only counted while idle; FETCH bubbles are expected.
      underrun <= lcden && ps_ready && !ps_valid && fifo_empty && (state == IDLE);

      if (flush) begin
        state    <= IDLE;
        idx      <= 5'd0;
        ps_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!fifo_empty) state <= FETCH;
          end
          FETCH: begin
            word_q   <= fifo_rdata;
            bpp_q    <= bpp_e'(lcdbpp);
            bepp_q   <= lcdbepp;
            idx      <= 5'd0;
            ps_data  <= ex_pixel;
            ps_valid <= 1'b1;
            state    <= SHIFT;
          end
          SHIFT: begin
            if (hs) begin
              if (!at_last) begin
                idx     <= idx + 5'd1;
                ps_data <= ex_pixel;
              end else begin
                ps_valid <= 1'b0;
                idx      <= 5'd0;
                state    <= fifo_empty ? IDLE : FETCH;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_pixel_unpacker.sv
// Self-checking bench for lcd_pixel_unpacker: a FIFO model feeds words,
// directed tests push expected pixels into a scoreboard queue and a monitor
// pops/compares on every accepted pixel.
module tb_lcd_pixel_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic        lcden;
  logic        frame_clr;
  logic [2:0]  lcdbpp;
  logic        lcdbepp;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [31:0] fifo_rdata = '0;
  logic [23:0] ps_data;
  logic        ps_valid;
  logic        ps_ready;
  logic        underrun;

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt = 0;

  logic [23:0] exp_q[$];
  logic [31:0] mem [0:63];
  int          rd_ptr = 0;
  int          wr_ptr = 0;

  always #5 clk = ~clk;

  lcd_pixel_unpacker dut (
    .clk        (clk),
    .rst        (rst),
    .lcden      (lcden),
    .frame_clr  (frame_clr),
    .lcdbpp     (lcdbpp),
    .lcdbepp    (lcdbepp),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_rdata (fifo_rdata),
    .ps_data    (ps_data),
    .ps_valid   (ps_valid),
    .ps_ready   (ps_ready),
    .underrun   (underrun)
  );

  // FIFO model: one-cycle read latency, pointers updated non-blocking.
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rd && rd_ptr != wr_ptr) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: scoreboard compare on each accepted pixel, pop-while-empty check.
  always @(negedge clk) begin
    if (!rst) begin
      if (ps_valid && ps_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pixel: got %h expected none", ps_data);
        end else begin
          check("pixel", {8'h0, ps_data}, {8'h0, exp_q.pop_front()});
        end
      end
      if (fifo_rd) begin
        rd_cnt++;
        check("rd_while_empty", {31'h0, fifo_empty}, 32'h0);
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic trace(input int n, output logic [15:0] v, output logic [15:0] r,
                       output logic [15:0] u);
    v = '0; r = '0; u = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v[i] = ps_valid;
      r[i] = fifo_rd;
      u[i] = underrun;
    end
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while (!(exp_q.size() == 0 && !ps_valid) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) check({name, "_drain_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_valid(input string name);
    int cyc = 0;
    @(negedge clk);
    while (!ps_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 20) check({name, "_valid_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    logic [15:0] v, r, u;
    int rd0;

    rst = 1'b1; lcden = 1'b0; frame_clr = 1'b0;
    lcdbpp = 3'b000; lcdbepp = 1'b0; ps_ready = 1'b0;

    #12;
    check("reset_ps_data",  {8'h0, ps_data}, 32'h0);
    check("reset_ps_valid", {31'h0, ps_valid}, 32'h0);
    check("reset_fifo_rd",  {31'h0, fifo_rd}, 32'h0);
    check("reset_underrun", {31'h0, underrun}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Starvation while idle: underrun from the cycle after conditions hold.
    @(posedge clk); #1 lcden = 1'b1; ps_ready = 1'b1;
    trace(4, v, r, u);
    check("underrun_starved", {28'h0, u[3:0]}, 32'hE);
    check("underrun_no_valid", {28'h0, v[3:0]}, 32'h0);
    @(posedge clk); #1 ps_ready = 1'b0;
    trace(2, v, r, u);
    check("underrun_ready_low", {30'h0, u[1:0]}, 32'h1);

    // 8bpp little-endian, two words back to back.
    @(posedge clk); #1;
    lcdbpp = 3'b011; lcdbepp = 1'b0; ps_ready = 1'b1;
    rd0 = rd_cnt;
    exp_q.push_back(24'h11); exp_q.push_back(24'h22);
    exp_q.push_back(24'h33); exp_q.push_back(24'h44);
    exp_q.push_back(24'h55); exp_q.push_back(24'h66);
    exp_q.push_back(24'h77); exp_q.push_back(24'h88);
    push_word(32'h44332211);
    push_word(32'h88776655);
    trace(12, v, r, u);
    check("bpp8_valid_pattern", {20'h0, v[11:0]}, 32'h7BC);
    check("bpp8_rd_pattern",    {20'h0, r[11:0]}, 32'h021);
    wait_drain("bpp8");
    check("bpp8_rd_count", rd_cnt - rd0, 32'd2);

    // 1bpp big-endian: first and last pixels set.
    @(posedge clk); #1;
    lcdbpp = 3'b000; lcdbepp = 1'b1;
    rd0 = rd_cnt;
    exp_q.push_back(24'h1);
    for (int i = 0; i < 30; i++) exp_q.push_back(24'h0);
    exp_q.push_back(24'h1);
    push_word(32'h80000001);
    wait_drain("bpp1");
    check("bpp1_rd_count", rd_cnt - rd0, 32'd1);

    // 24bpp: one pixel per word, one bubble between words.
    @(posedge clk); #1;
    lcdbpp = 3'b101; lcdbepp = 1'b1;
    exp_q.push_back(24'hABCDEF);
    exp_q.push_back(24'h123456);
    push_word(32'hFFABCDEF);
    push_word(32'h00123456);
    trace(6, v, r, u);
    check("bpp24_valid_pattern", {26'h0, v[5:0]}, 32'h14);
    check("bpp24_rd_pattern",    {26'h0, r[5:0]}, 32'h05);
    wait_drain("bpp24");

    // Backpressure at 16bpp 5:6:5.
    @(posedge clk); #1;
    lcdbpp = 3'b110; lcdbepp = 1'b0; ps_ready = 1'b0;
    exp_q.push_back(24'h00CAFE);
    exp_q.push_back(24'h00BEEF);
    push_word(32'hBEEFCAFE);
    wait_valid("bp");
    for (int i = 0; i < 3; i++) begin
      check("bp_hold", {7'h0, ps_valid, ps_data}, {7'h0, 1'b1, 24'h00CAFE});
      if (i < 2) @(negedge clk);
    end
    @(posedge clk); #1 ps_ready = 1'b1;
    wait_drain("bp");

    // Mode change mid-word takes effect on the next word only.
    @(posedge clk); #1;
    lcdbpp = 3'b011; lcdbepp = 1'b0;
    exp_q.push_back(24'h11); exp_q.push_back(24'h22);
    exp_q.push_back(24'h33); exp_q.push_back(24'h44);
    for (int i = 1; i <= 8; i++) exp_q.push_back(24'(i));
    push_word(32'h44332211);
    push_word(32'h87654321);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 lcdbpp = 3'b010;
    wait_drain("mode_change");

    // frame_clr during FETCH discards the returning word.
    @(posedge clk); #1;
    lcdbpp = 3'b011;
    rd0 = rd_cnt;
    push_word(32'hDEADBEEF);
    @(posedge clk); #1 frame_clr = 1'b1;
    @(posedge clk); #1 frame_clr = 1'b0;
    @(negedge clk);
    check("flush_valid_low", {31'h0, ps_valid}, 32'h0);
    trace(5, v, r, u);
    check("flush_no_output", {27'h0, v[4:0]}, 32'h0);
    check("flush_rd_count", rd_cnt - rd0, 32'd1);

    // Asynchronous reset mid-SHIFT clears outputs without a clock edge.
    @(posedge clk); #1;
    ps_ready = 1'b0;
    push_word(32'h01020304);
    wait_valid("arst");
    #2 rst = 1'b1;
    #1;
    check("arst_ps_valid", {31'h0, ps_valid}, 32'h0);
    check("arst_ps_data",  {8'h0, ps_data}, 32'h0);
    check("arst_fifo_rd",  {31'h0, fifo_rd}, 32'h0);
    check("arst_underrun", {31'h0, underrun}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    trace(4, v, r, u);
    check("arst_idle_after", {28'h0, v[3:0]}, 32'h0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $finish;
  end

endmodule
